rob_cmplt_arb: RTL and testbench

Completion arbiter in front of the reorder buffer's completion port. Up to NUM_SRC execution units (ALU, AGU, load/store, branch) each present the ROB tag of a finished instruction. The ROB accepts at most GRANT_WIDTH completion tags per cycle with no backpressure. This block selects up to GRANT_WIDTH requesters per cycle round-robin, back-pressures the rest, and drives a registered, packed completion bus into the ROB.

---
 rtl/rob_pkg.sv | 11 +
 rtl/rob_rr_pick.sv | 29 ++
 rtl/rob_cmplt_arb.sv | 114 +++++++++++
 tb/tb_rob_cmplt_arb.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared reorder-buffer sizing constants and the ROB tag type, used by the ROB and its completion arbiter.
package rob_pkg;

    localparam int ROB_ELEMENTS = 15;
    localparam int ROB_SLOTS    = 16;
    localparam int TAG_WIDTH    = $clog2(ROB_SLOTS);
    localparam int CMPLT_WIDTH  = 3;

    typedef logic [TAG_WIDTH-1:0] rob_tag_t;

endpackage

// File: rtl/rob_rr_pick.sv
// Finds the first set request bit scanning upward (with wrap) from a start index.
// Returns a one-hot grant, the index of that bit, and whether any bit was found.
module rob_rr_pick #(
    parameter int N  = 6,
    parameter int IW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          found
);

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            logic [IW-1:0] s;
            s = IW'((int'(start) + k) % N);
            if (!found && req[s]) begin
                grant[s] = 1'b1;
                idx      = s;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rob_cmplt_arb.sv
// Round-robin completion arbiter packing up to GRANT_WIDTH finished tags per cycle onto the ROB completion bus.
// Optional sticky duplicate-tag detection is built when ROB_CMPLT_ARB_DUP_CHECK_EN is defined.
module rob_cmplt_arb
    import rob_pkg::*;
#(
    parameter int NUM_SRC     = 6,
    parameter int TAG_WIDTH   = rob_pkg::TAG_WIDTH,
    parameter int GRANT_WIDTH = rob_pkg::CMPLT_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic [NUM_SRC*TAG_WIDTH-1:0]     req_tag,
    input  logic [NUM_SRC-1:0]               req_valid,
    output logic [NUM_SRC-1:0]               req_ready,
    output logic [GRANT_WIDTH*TAG_WIDTH-1:0] cmplt_tag,
    output logic [GRANT_WIDTH-1:0]           cmplt_valid,
    output logic                             dup_err
);

    localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [PW-1:0]                    rr_ptr;
    logic [PW-1:0]                    next_ptr;
    logic [NUM_SRC-1:0]               avail       [GRANT_WIDTH];
    logic [NUM_SRC-1:0]               stage_grant [GRANT_WIDTH];
    logic [PW-1:0]                    stage_idx   [GRANT_WIDTH];
    logic [PW-1:0]                    stage_start [GRANT_WIDTH];
    logic [GRANT_WIDTH-1:0]           stage_found;
    logic [NUM_SRC-1:0]               grant_any;
    logic [GRANT_WIDTH*TAG_WIDTH-1:0] slot_tag;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] i);
        return (int'(i) == NUM_SRC - 1) ? '0 : i + 1'b1;
    endfunction

    assign avail[0]       = req_valid;
    assign stage_start[0] = rr_ptr;

    // Each stage picks from what earlier stages left, resuming just past the previous winner,
    // so the chain of winners is exactly the scan order and slot j gets the j-th winner.
    for (genvar g = 0; g < GRANT_WIDTH; g++) begin : g_stage
        rob_rr_pick #(
            .N  (NUM_SRC),
            .IW (PW)
        ) u_pick (
            .req   (avail[g]),
            .start (stage_start[g]),
            .grant (stage_grant[g]),
            .idx   (stage_idx[g]),
            .found (stage_found[g])
        );
        if (g < GRANT_WIDTH - 1) begin : g_next
            assign avail[g+1]       = avail[g] & ~stage_grant[g];
            assign stage_start[g+1] = wrap_inc(stage_idx[g]);
        end
    end

    always_comb begin
        grant_any = '0;
        slot_tag  = '0;
        next_ptr  = rr_ptr;
        for (int g = 0; g < GRANT_WIDTH; g++) begin
            grant_any = grant_any | stage_grant[g];
            if (stage_found[g]) begin
                slot_tag[g*TAG_WIDTH +: TAG_WIDTH] = req_tag[int'(stage_idx[g])*TAG_WIDTH +: TAG_WIDTH];
                next_ptr = wrap_inc(stage_idx[g]);
            end
        end
    end

    assign req_ready = (rst || flush) ? '0 : grant_any;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= '0;
            cmplt_valid <= '0;
            cmplt_tag   <= '0;
        end else if (flush) begin
            cmplt_valid <= '0;
            cmplt_tag   <= '0;
        end else begin
            rr_ptr      <= next_ptr;
            cmplt_valid <= stage_found;
            cmplt_tag   <= slot_tag;
        end
    end

`ifdef ROB_CMPLT_ARB_DUP_CHECK_EN
    logic dup_now;

    // Inspects the bus already presented to the ROB, so the flag rises one cycle after the duplicates appear.
    always_comb begin
        dup_now = 1'b0;
        for (int a = 0; a < GRANT_WIDTH; a++) begin
            for (int b = a + 1; b < GRANT_WIDTH; b++) begin
                if (cmplt_valid[a] && cmplt_valid[b] &&
                    cmplt_tag[a*TAG_WIDTH +: TAG_WIDTH] == cmplt_tag[b*TAG_WIDTH +: TAG_WIDTH])
                    dup_now = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            dup_err <= 1'b0;
        else if (dup_now)
            dup_err <= 1'b1;
    end
`else
    assign dup_err = 1'b0;
`endif

endmodule

// File: tb/tb_rob_cmplt_arb.sv
// Scoreboard bench for rob_cmplt_arb: a reference model predicts grants and the next-cycle completion bus.
module tb_rob_cmplt_arb;

    localparam int NS = 6;
    localparam int TW = 4;
    localparam int GW = 3;

    typedef struct packed {
        logic [GW-1:0]    valid;
        logic [GW*TW-1:0] tag;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic [NS*TW-1:0]  req_tag = '0;
    logic [NS-1:0]     req_valid = '0;
    logic [NS-1:0]     req_ready;
    logic [GW*TW-1:0]  cmplt_tag;
    logic [GW-1:0]     cmplt_valid;
    logic              dup_err;

    exp_t      sb_q[$];
    bit        pend_v   [NS];
    logic [TW-1:0] pend_tag [NS];
    int        model_ptr = 0;
    bit        model_dup = 0;
    int        vectors = 0;
    int        miscompares = 0;

    rob_cmplt_arb #(
        .NUM_SRC     (NS),
        .TAG_WIDTH   (TW),
        .GRANT_WIDTH (GW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .req_tag     (req_tag),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .cmplt_tag   (cmplt_tag),
        .cmplt_valid (cmplt_valid),
        .dup_err     (dup_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int src, input logic [TW-1:0] tag);
        pend_v[src]   = 1'b1;
        pend_tag[src] = tag;
    endtask

    // One clock: drive pending requests, predict grants, check ready, then check the registered bus.
    task automatic run_cycle(input bit do_rst, input bit do_flush);
        logic [NS-1:0] exp_ready;
        exp_t          e;
        int            cnt, last;
        rst   = do_rst;
        flush = do_flush;
        for (int i = 0; i < NS; i++) begin
            req_valid[i]          = pend_v[i];
            req_tag[i*TW +: TW]   = pend_v[i] ? pend_tag[i] : TW'($urandom_range(15));
        end
        exp_ready = '0;
        e         = '0;
        cnt       = 0;
        last      = -1;
        if (!do_rst && !do_flush) begin
            for (int k = 0; k < NS; k++) begin
                int s;
                s = (model_ptr + k) % NS;
                if (pend_v[s] && cnt < GW) begin
                    exp_ready[s]          = 1'b1;
                    e.valid[cnt]          = 1'b1;
                    e.tag[cnt*TW +: TW]   = pend_tag[s];
                    cnt++;
                    last = s;
                end
            end
        end
        sb_q.push_back(e);
        @(negedge clk);
        checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
        @(posedge clk);
        #1;
        if (do_rst) begin
            model_ptr = 0;
            model_dup = 0;
            for (int i = 0; i < NS; i++) pend_v[i] = 1'b0;
        end else if (cnt > 0) begin
            model_ptr = (last + 1) % NS;
        end
        for (int i = 0; i < NS; i++) if (exp_ready[i]) pend_v[i] = 1'b0;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checkOutput("cmplt_valid", 32'(cmplt_valid), 32'(e.valid));
            checkOutput("cmplt_tag", 32'(cmplt_tag), 32'(e.tag));
            checkOutput("dup_err", 32'(dup_err), 32'(model_dup));
`ifdef ROB_CMPLT_ARB_DUP_CHECK_EN
            for (int a = 0; a < GW; a++)
                for (int b = a + 1; b < GW; b++)
                    if (e.valid[a] && e.valid[b] && e.tag[a*TW +: TW] == e.tag[b*TW +: TW])
                        model_dup = 1'b1;
`endif
        end
    endtask

    initial begin
        for (int i = 0; i < NS; i++) begin
            pend_v[i]   = 1'b0;
            pend_tag[i] = '0;
        end

        run_cycle(1, 0);
        run_cycle(1, 0);
        run_cycle(0, 0);
        run_cycle(0, 0);

        applyStimulus(0, 4'd5);
        applyStimulus(1, 4'd9);
        run_cycle(0, 0);
        run_cycle(0, 0);

        run_cycle(1, 0);
        for (int i = 0; i < NS; i++) applyStimulus(i, TW'(i + 1));
        run_cycle(0, 0);
        run_cycle(0, 0);
        run_cycle(0, 0);

        for (int i = 0; i < 4; i++) applyStimulus(i, TW'(i + 2));
        run_cycle(0, 0);
        run_cycle(0, 0);
        applyStimulus(5, 4'd8);
        applyStimulus(0, 4'd10);
        applyStimulus(1, 4'd11);
        applyStimulus(2, 4'd12);
        run_cycle(0, 0);
        run_cycle(0, 0);

        applyStimulus(3, 4'd6);
        run_cycle(0, 1);
        run_cycle(0, 0);
        run_cycle(0, 0);

        applyStimulus(0, 4'd7);
        applyStimulus(3, 4'd7);
        run_cycle(0, 0);
        run_cycle(0, 0);
        run_cycle(0, 0);
        run_cycle(0, 0);

        for (int c = 0; c < 60; c++) begin
            for (int i = 0; i < NS; i++)
                if (!pend_v[i] && $urandom_range(1) == 1) applyStimulus(i, TW'($urandom_range(15)));
            run_cycle(0, $urandom_range(7) == 0);
        end

        for (int i = 0; i < NS; i++) applyStimulus(i, TW'(i + 9));
        run_cycle(0, 0);
        run_cycle(1, 0);
        run_cycle(0, 0);
        applyStimulus(2, 4'd3);
        applyStimulus(4, 4'd14);
        run_cycle(0, 0);
        run_cycle(0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
